// File: rtl/neuron_wb_pkg.sv
// Shared definitions for the neuron parameter Wishbone initiator:
// FSM state encoding, parameter-segment address map and word bit fields.
package neuron_wb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_GAP  = 2'd2,
        ST_RESP = 2'd3
    } wb_state_e;

    // Parameter segment address map (byte addresses)
    localparam logic [31:0] PARAM_BASE    = 32'h3000_4000;
    localparam logic [31:0] NEURON_STRIDE = 32'd16;
    localparam logic [31:0] WORD_OFFSET   = 32'd16;

    // Byte lanes
    localparam logic [3:0] SEL_ALL = 4'hF;
    localparam logic [3:0] SEL_VP  = 4'b1000;

    // Word 0 fields
    localparam int VP_MSB    = 31;
    localparam int VP_LSB    = 24;
    localparam int RESET_MSB = 23;
    localparam int RESET_LSB = 16;
    localparam int LEAK_MSB  = 15;
    localparam int LEAK_LSB  = 8;
    localparam int THR_MSB   = 7;
    localparam int THR_LSB   = 0;
    // Words 1.. carry synaptic weights over the full word
    localparam int WEIGHT_MSB = 31;
    localparam int WEIGHT_LSB = 0;

    // Byte address of parameter word k of a neuron; 32-bit wrap is intended.
    function automatic logic [31:0] word_addr(input logic [7:0] neuron, input logic [1:0] k);
        return PARAM_BASE + ({24'h0, neuron} * NEURON_STRIDE) + WORD_OFFSET + {28'h0, k, 2'b00};
    endfunction

endpackage

// File: rtl/neuron_param_wb_initiator_timeout.sv
// Cycle counter bounding how long STB may wait for ACK.
// expired is high during the LIMIT-th enabled cycle since the last clear.
module wb_timeout_counter #(
    parameter int unsigned LIMIT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic clear,
    output logic expired
);
    localparam int unsigned CW = (LIMIT < 2) ? 1 : $clog2(LIMIT + 1);

    logic [CW-1:0] count_q;

    // Count enabled cycles; hold once the limit is reached
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (enable && !expired) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign expired = (count_q == CW'(LIMIT - 1));

endmodule

// File: rtl/neuron_param_wb_initiator.sv
// Wishbone classic initiator that fetches a neuron's parameter words or
// writes back its voltage potential byte.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | waiting for a scheduler command, cmd_ready_o high
// REQ     | CYC/STB asserted for word k, waiting for ACK or timeout
// GAP     | bus released, waiting for the slave to drop a held ACK
// RESP    | result presented until the scheduler takes it
module neuron_param_wb_initiator
    import neuron_wb_pkg::*;
#(
    parameter int unsigned WORDS_PER_NEURON = 3,
    parameter int unsigned TIMEOUT_CYCLES   = 255
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [3:0]  wbm_sel_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic        wbm_ack_i,
    input  logic [31:0] wbm_dat_i,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic        cmd_write_i,
    input  logic [7:0]  cmd_neuron_i,
    input  logic [7:0]  cmd_vp_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic        rsp_error_o,
    output logic [31:0] param_word0_o,
    output logic [31:0] param_word1_o,
    output logic [31:0] param_word2_o,
    output logic [31:0] param_word3_o
);

    wb_state_e   state_q, state_d;
    logic [7:0]  neuron_q;
    logic [7:0]  vp_q;
    logic        write_q;
    logic [1:0]  k_q;
    logic [31:0] words_q [4];
    logic        error_q;

    logic        accept;
    logic        capture;
    logic        advance;
    logic        timeout;
    logic        rsp_done;
    logic        tmo_enable;
    logic        tmo_expired;
    logic        last_word;

    assign last_word = (k_q == 2'(WORDS_PER_NEURON - 1));

    wb_timeout_counter #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (wb_clk_i),
        .rst     (wb_rst_i),
        .enable  (tmo_enable),
        .clear   (state_q != ST_REQ),
        .expired (tmo_expired)
    );

    // State register; async reset drops CYC/STB immediately
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and bus/handshake outputs; bus fields are zero outside REQ
    always_comb begin
        state_d     = state_q;
        cmd_ready_o = 1'b0;
        rsp_valid_o = 1'b0;
        wbm_cyc_o   = 1'b0;
        wbm_stb_o   = 1'b0;
        wbm_we_o    = 1'b0;
        wbm_sel_o   = 4'h0;
        wbm_adr_o   = 32'h0;
        wbm_dat_o   = 32'h0;
        accept      = 1'b0;
        capture     = 1'b0;
        advance     = 1'b0;
        timeout     = 1'b0;
        rsp_done    = 1'b0;
        tmo_enable  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cmd_ready_o = 1'b1;
                if (cmd_valid_i) begin
                    accept  = 1'b1;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                wbm_cyc_o  = 1'b1;
                wbm_stb_o  = 1'b1;
                wbm_we_o   = write_q;
                wbm_sel_o  = write_q ? SEL_VP : SEL_ALL;
                wbm_adr_o  = word_addr(neuron_q, k_q);
                wbm_dat_o[VP_MSB:VP_LSB] = vp_q;
                tmo_enable = 1'b1;
                if (wbm_ack_i) begin
                    capture = !write_q;
                    state_d = ST_GAP;
                end else if (tmo_expired) begin
                    timeout = 1'b1;
                    state_d = ST_RESP;
                end
            end
            ST_GAP: begin
                // Slaves may hold ACK until they see CYC low
                if (!wbm_ack_i) begin
                    if (write_q || last_word) begin
                        state_d = ST_RESP;
                    end else begin
                        advance = 1'b1;
                        state_d = ST_REQ;
                    end
                end
            end
            ST_RESP: begin
                rsp_valid_o = 1'b1;
                if (rsp_ready_i) begin
                    rsp_done = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Command latch, word index, fetched words and error flag
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            neuron_q <= 8'h0;
            vp_q     <= 8'h0;
            write_q  <= 1'b0;
            k_q      <= 2'd0;
            error_q  <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                words_q[i] <= 32'h0;
            end
        end else begin
            if (accept) begin
                neuron_q <= cmd_neuron_i;
                vp_q     <= cmd_vp_i;
                write_q  <= cmd_write_i;
                k_q      <= 2'd0;
            end
            if (advance) begin
                k_q <= k_q + 2'd1;
            end
            if (capture) begin
                words_q[k_q] <= wbm_dat_i;
            end
            if (timeout) begin
                error_q <= 1'b1;
            end else if (rsp_done) begin
                error_q <= 1'b0;
            end
        end
    end

    assign rsp_error_o   = error_q;
    assign param_word0_o = (WORDS_PER_NEURON > 0) ? words_q[0] : 32'h0;
    assign param_word1_o = (WORDS_PER_NEURON > 1) ? words_q[1] : 32'h0;
    assign param_word2_o = (WORDS_PER_NEURON > 2) ? words_q[2] : 32'h0;
    assign param_word3_o = (WORDS_PER_NEURON > 3) ? words_q[3] : 32'h0;

endmodule

// File: tb/tb_neuron_param_wb_initiator.sv
// Self-checking bench for neuron_param_wb_initiator with a small Wishbone slave model.
module tb_neuron_param_wb_initiator;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cyc, stb, we;
    logic [3:0]  sel;
    logic [31:0] adr, dat_o;
    logic        ack;
    logic [31:0] dat_i;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [7:0]  cmd_neuron = 8'h0;
    logic [7:0]  cmd_vp = 8'h0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic        rsp_error;
    logic [31:0] w0, w1, w2, w3;

    typedef struct {
        logic [31:0] adr;
        logic        we;
        logic [3:0]  sel;
        logic [31:0] dat;
    } xfer_t;

    xfer_t       exp_q[$];
    logic [31:0] exp_words [4];
    logic [31:0] slave_mem [4];
    int          ack_mode = 0;   // 0: ACK with STB, 1: ACK held 3 cycles after CYC falls, 2: never
    logic [1:0]  hold_cnt = 2'd0;

    int tests_run = 0;
    int fails = 0;
    int stb_cycles, xfers, hold_viol, rsp_cycle;

    neuron_param_wb_initiator dut (
        .wb_clk_i      (clk),
        .wb_rst_i      (rst),
        .wbm_cyc_o     (cyc),
        .wbm_stb_o     (stb),
        .wbm_we_o      (we),
        .wbm_sel_o     (sel),
        .wbm_adr_o     (adr),
        .wbm_dat_o     (dat_o),
        .wbm_ack_i     (ack),
        .wbm_dat_i     (dat_i),
        .cmd_valid_i   (cmd_valid),
        .cmd_ready_o   (cmd_ready),
        .cmd_write_i   (cmd_write),
        .cmd_neuron_i  (cmd_neuron),
        .cmd_vp_i      (cmd_vp),
        .rsp_valid_o   (rsp_valid),
        .rsp_ready_i   (rsp_ready),
        .rsp_error_o   (rsp_error),
        .param_word0_o (w0),
        .param_word1_o (w1),
        .param_word2_o (w2),
        .param_word3_o (w3)
    );

    always #5 clk = ~clk;

    always_comb begin
        dat_i = slave_mem[adr[3:2]];
        if (ack_mode == 2) ack = 1'b0;
        else               ack = (cyc && stb) || (hold_cnt != 2'd0);
    end

    always @(posedge clk) begin
        if (ack_mode == 1 && cyc && stb) hold_cnt <= 2'd3;
        else if (hold_cnt != 2'd0)       hold_cnt <= hold_cnt - 2'd1;
    end

    function automatic logic [31:0] tb_addr(input logic [7:0] n, input int k);
        return 32'h3000_4000 + 32'(n) * 32'd16 + 32'd16 + 32'(k) * 32'd4;
    endfunction

    task automatic issue(input logic wr, input logic [7:0] n, input logic [7:0] vp, input int nx);
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_write = wr; cmd_neuron = n; cmd_vp = vp;
        for (int k = 0; k < nx; k++) begin
            xfer_t e;
            e.adr = tb_addr(n, k);
            e.we  = wr;
            e.sel = wr ? 4'b1000 : 4'hF;
            e.dat = {vp, 24'h0};
            exp_q.push_back(e);
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    // Sample each cycle at negedge until rsp_valid; pops the scoreboard on every transfer.
    task automatic run_until_rsp(input int budget);
        logic done;
        done = 1'b0;
        rsp_cycle = 0; stb_cycles = 0; xfers = 0; hold_viol = 0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            rsp_cycle++;
            if (stb && hold_cnt != 2'd0) hold_viol++;
            if (stb) stb_cycles++;
            if (cyc && stb && ack) begin
                xfer_t e;
                xfers++;
                tests_run++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL xfer_unexpected: got adr=%h we=%b sel=%h, required no transfer", adr, we, sel);
                end else begin
                    e = exp_q.pop_front();
                    if ({adr, we, sel, dat_o} !== {e.adr, e.we, e.sel, e.dat}) begin
                        fails++;
                        $display("FAIL xfer: got adr=%h we=%b sel=%h dat=%h, required adr=%h we=%b sel=%h dat=%h",
                                 adr, we, sel, dat_o, e.adr, e.we, e.sel, e.dat);
                    end
                end
            end
            if (rsp_valid) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) begin
            tests_run++;
            fails++;
            $display("FAIL rsp_wait: no rsp_valid within %0d cycles", budget);
        end
    endtask

    task automatic finish_rsp();
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if ({cyc, stb, we, sel, cmd_ready, rsp_valid, rsp_error} !== 10'b000_0000_100) begin
            fails++;
            $display("FAIL reset_ctrl: got %b, required %b", {cyc, stb, we, sel, cmd_ready, rsp_valid, rsp_error}, 10'b000_0000_100);
        end
        tests_run++;
        if ({adr, dat_o} !== 64'h0) begin
            fails++;
            $display("FAIL reset_bus: got adr=%h dat=%h, required 0", adr, dat_o);
        end
        tests_run++;
        if ({w3, w2, w1, w0} !== 128'h0) begin
            fails++;
            $display("FAIL reset_words: got %h, required 0", {w3, w2, w1, w0});
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) exp_words[i] = 32'h0;
    endtask

    task automatic test_read_basic();
        ack_mode = 0;
        slave_mem[0] = 32'h1122_3344; slave_mem[1] = 32'h5566_7788;
        slave_mem[2] = 32'h99AA_BBCC; slave_mem[3] = 32'hDEAD_BEEF;
        issue(1'b0, 8'd0, 8'h3C, 3);
        run_until_rsp(50);
        exp_words[0] = 32'h1122_3344; exp_words[1] = 32'h5566_7788;
        exp_words[2] = 32'h99AA_BBCC; exp_words[3] = 32'h0;
        tests_run++;
        if (rsp_cycle !== 7) begin
            fails++;
            $display("FAIL read_latency: got rsp on cycle %0d, required 7", rsp_cycle);
        end
        tests_run++;
        if ({w3, w2, w1, w0} !== {exp_words[3], exp_words[2], exp_words[1], exp_words[0]}) begin
            fails++;
            $display("FAIL read_words: got %h %h %h %h, required %h %h %h %h",
                     w0, w1, w2, w3, exp_words[0], exp_words[1], exp_words[2], exp_words[3]);
        end
        tests_run++;
        if (rsp_error !== 1'b0 || xfers !== 3) begin
            fails++;
            $display("FAIL read_status: got err=%b xfers=%0d, required err=0 xfers=3", rsp_error, xfers);
        end
        finish_rsp();
        tests_run++;
        if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || exp_q.size() != 0) begin
            fails++;
            $display("FAIL read_release: got ready=%b valid=%b left=%0d, required 1 0 0", cmd_ready, rsp_valid, exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_ack_hold();
        ack_mode = 1;
        slave_mem[0] = 32'hA0A0_0001; slave_mem[1] = 32'hB0B0_0002; slave_mem[2] = 32'hC0C0_0003;
        issue(1'b0, 8'd1, 8'h00, 3);
        run_until_rsp(100);
        exp_words[0] = 32'hA0A0_0001; exp_words[1] = 32'hB0B0_0002; exp_words[2] = 32'hC0C0_0003;
        tests_run++;
        if (hold_viol !== 0 || xfers !== 3) begin
            fails++;
            $display("FAIL hold_protocol: got stb_while_ack=%0d xfers=%0d, required 0 and 3", hold_viol, xfers);
        end
        tests_run++;
        if (rsp_cycle !== 16) begin
            fails++;
            $display("FAIL hold_latency: got rsp on cycle %0d, required 16", rsp_cycle);
        end
        tests_run++;
        if ({w2, w1, w0, rsp_error} !== {exp_words[2], exp_words[1], exp_words[0], 1'b0}) begin
            fails++;
            $display("FAIL hold_words: got %h %h %h err=%b", w0, w1, w2, rsp_error);
        end
        finish_rsp();
        repeat (4) @(posedge clk);
        ack_mode = 0;
        tests_run++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL hold_left: got %0d pending transfers, required 0", exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_write();
        ack_mode = 0;
        issue(1'b1, 8'd5, 8'hF6, 1);
        run_until_rsp(50);
        tests_run++;
        if (xfers !== 1 || rsp_cycle !== 3 || rsp_error !== 1'b0) begin
            fails++;
            $display("FAIL write_status: got xfers=%0d cycle=%0d err=%b, required 1 3 0", xfers, rsp_cycle, rsp_error);
        end
        tests_run++;
        if ({w3, w2, w1, w0} !== {exp_words[3], exp_words[2], exp_words[1], exp_words[0]}) begin
            fails++;
            $display("FAIL write_words_kept: got %h %h %h %h", w0, w1, w2, w3);
        end
        finish_rsp();
        exp_q.delete();
    endtask

    task automatic test_rsp_stall();
        ack_mode = 0;
        slave_mem[0] = 32'h0101_0101; slave_mem[1] = 32'h0202_0202; slave_mem[2] = 32'h0303_0303;
        issue(1'b0, 8'd9, 8'h00, 3);
        run_until_rsp(50);
        exp_words[0] = 32'h0101_0101; exp_words[1] = 32'h0202_0202; exp_words[2] = 32'h0303_0303;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_neuron = 8'hAA;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            tests_run++;
            if ({rsp_valid, cmd_ready, cyc, stb, rsp_error} !== 5'b10000) begin
                fails++;
                $display("FAIL stall_ctrl[%0d]: got valid,ready,cyc,stb,err=%b, required 10000", i,
                         {rsp_valid, cmd_ready, cyc, stb, rsp_error});
            end
            tests_run++;
            if ({w2, w1, w0} !== {exp_words[2], exp_words[1], exp_words[0]}) begin
                fails++;
                $display("FAIL stall_words[%0d]: got %h %h %h", i, w0, w1, w2);
            end
        end
        cmd_valid = 1'b0;
        finish_rsp();
        exp_q.delete();
    endtask

    task automatic test_timeout();
        ack_mode = 2;
        issue(1'b0, 8'd7, 8'h00, 0);
        run_until_rsp(400);
        tests_run++;
        if (stb_cycles !== 255) begin
            fails++;
            $display("FAIL timeout_len: got STB high %0d cycles, required 255", stb_cycles);
        end
        tests_run++;
        if ({rsp_valid, rsp_error, cyc, stb} !== 4'b1100) begin
            fails++;
            $display("FAIL timeout_rsp: got valid,err,cyc,stb=%b, required 1100", {rsp_valid, rsp_error, cyc, stb});
        end
        tests_run++;
        if ({w2, w1, w0} !== {exp_words[2], exp_words[1], exp_words[0]}) begin
            fails++;
            $display("FAIL timeout_words_kept: got %h %h %h", w0, w1, w2);
        end
        finish_rsp();
        tests_run++;
        if (rsp_error !== 1'b0 || cmd_ready !== 1'b1) begin
            fails++;
            $display("FAIL timeout_clear: got err=%b ready=%b, required 0 1", rsp_error, cmd_ready);
        end
        ack_mode = 0;
        slave_mem[0] = 32'hFEED_0000; slave_mem[1] = 32'hFEED_0001; slave_mem[2] = 32'hFEED_0002;
        issue(1'b0, 8'd255, 8'h00, 3);
        run_until_rsp(50);
        exp_words[0] = 32'hFEED_0000; exp_words[1] = 32'hFEED_0001; exp_words[2] = 32'hFEED_0002;
        tests_run++;
        if ({w2, w1, w0, rsp_error} !== {exp_words[2], exp_words[1], exp_words[0], 1'b0}) begin
            fails++;
            $display("FAIL after_timeout_read: got %h %h %h err=%b", w0, w1, w2, rsp_error);
        end
        finish_rsp();
        exp_q.delete();
    endtask

    task automatic test_random_reads();
        ack_mode = 0;
        for (int it = 0; it < 4; it++) begin
            logic [7:0] n;
            n = 8'($urandom_range(0, 255));
            for (int k = 0; k < 4; k++) slave_mem[k] = $urandom;
            issue(1'b0, n, 8'($urandom_range(0, 255)), 3);
            run_until_rsp(50);
            for (int k = 0; k < 3; k++) exp_words[k] = slave_mem[k];
            tests_run++;
            if ({w3, w2, w1, w0, rsp_error} !== {32'h0, exp_words[2], exp_words[1], exp_words[0], 1'b0}
                || rsp_cycle !== 7) begin
                fails++;
                $display("FAIL rand_read[%0d]: n=%0d got %h %h %h %h cycle=%0d err=%b", it, n, w0, w1, w2, w3,
                         rsp_cycle, rsp_error);
            end
            finish_rsp();
            tests_run++;
            if (exp_q.size() != 0) begin
                fails++;
                $display("FAIL rand_left[%0d]: got %0d pending, required 0", it, exp_q.size());
            end
            exp_q.delete();
        end
    endtask

    task automatic test_reset_mid();
        logic hit;
        ack_mode = 0;
        hit = 1'b0;
        slave_mem[0] = 32'h7777_0000; slave_mem[1] = 32'h7777_0001; slave_mem[2] = 32'h7777_0002;
        issue(1'b0, 8'd2, 8'h00, 0);
        for (int c = 0; c < 20; c++) begin
            if (stb && adr === tb_addr(8'd2, 1)) begin
                hit = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        tests_run++;
        if (!hit || w0 !== 32'h7777_0000) begin
            fails++;
            $display("FAIL mid_setup: got reached_word1=%b w0=%h, required 1 77770000", hit, w0);
        end
        rst = 1'b1;
        #1;
        tests_run++;
        if ({cyc, stb, cmd_ready, rsp_valid} !== 4'b0010) begin
            fails++;
            $display("FAIL mid_reset_ctrl: got cyc,stb,ready,valid=%b, required 0010", {cyc, stb, cmd_ready, rsp_valid});
        end
        tests_run++;
        if ({w3, w2, w1, w0} !== 128'h0) begin
            fails++;
            $display("FAIL mid_reset_words: got %h, required 0", {w3, w2, w1, w0});
        end
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
    endtask

    initial begin
        for (int k = 0; k < 4; k++) slave_mem[k] = 32'h0;
        test_reset();
        test_read_basic();
        test_ack_hold();
        test_write();
        test_rsp_stall();
        test_timeout();
        test_random_reads();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule

// File: doc/neuron_param_wb_initiator.md
Name: neuron_param_wb_initiator

Overview:
- Wishbone classic master that fetches or writes back neuron parameter words in the 256x256 neuron-core parameter segment.
- Read: given a neuron index, performs WORDS_PER_NEURON single-word read cycles and presents the assembled words to the scheduler.
- Write-back: performs one byte-masked write that updates a neuron's voltage potential (word 0, bits [31:24]).
- Sits between the core scheduler (command/response side) and the Wishbone interconnect that reaches the per-neuron parameter slaves.

Parameters:
- PARAM_BASE, 32'h30004000, base address of the parameter segment.
- NEURON_STRIDE, 16, byte stride between consecutive neurons' parameter blocks.
- WORD_OFFSET, 16, byte offset from a neuron block base to its word 0.
- WORDS_PER_NEURON, 3, 32-bit words fetched per read command (1..4).
- TIMEOUT_CYCLES, 255, maximum cycles STB may wait for ACK before abort (8-bit counter).

Ports:
- wb_clk_i  in  1  clock; all logic on rising edge.
- wb_rst_i  in  1  reset, asynchronous, active-high.
- wbm_cyc_o  out  1  Wishbone cycle.
- wbm_stb_o  out  1  Wishbone strobe.
- wbm_we_o  out  1  1 = write.
- wbm_sel_o  out  4  byte lanes.
- wbm_adr_o  out  32  byte address.
- wbm_dat_o  out  32  write data.
- wbm_ack_i  in  1  slave acknowledge; may be held high until CYC falls.
- wbm_dat_i  in  32  read data.
- cmd_valid_i  in  1  command request.
- cmd_ready_o  out  1  high only in IDLE.
- cmd_write_i  in  1  0 = fetch, 1 = voltage write-back.
- cmd_neuron_i  in  8  neuron index 0..255.
- cmd_vp_i  in  8  voltage potential to write (write command only).
- rsp_valid_o  out  1  command complete.
- rsp_ready_i  in  1  scheduler accepts the response.
- rsp_error_o  out  1  timeout occurred; valid while rsp_valid_o is high.
- param_word0_o, param_word1_o, param_word2_o, param_word3_o  out  32 each  fetched words; words at index >= WORDS_PER_NEURON read as 0.

Behaviour:
- Reset: all outputs 0 except cmd_ready_o = 1; state IDLE; word registers, counters and timeout counter cleared.
- Reset asserted mid-cycle drops CYC/STB immediately (asynchronous).
- Address of word k: PARAM_BASE + cmd_neuron*NEURON_STRIDE + WORD_OFFSET + 4*k, in 32-bit arithmetic with wrap.
- Neuron index and vp are latched at command acceptance.
- States:
  - IDLE: cmd_ready_o = 1. On cmd_valid_i, latch the command, set k = 0, go to REQ. REQ is visible on the bus the following cycle.
  - REQ: CYC = STB = 1; WE = cmd_write; SEL = 4'hF for reads, 4'b1000 for writes; dat_o = {vp, 24'h0}; timeout counter increments each cycle.
    - On wbm_ack_i: capture wbm_dat_i into word k (read only), drop CYC/STB on the next edge, go to GAP.
    - If the counter reaches TIMEOUT_CYCLES without ACK: drop CYC/STB, set error, go to RESP.
  - GAP: CYC = STB = 0. Wait until wbm_ack_i = 0; this is mandatory because slaves hold ACK until they see CYC low. Then:
    - write command, or k == WORDS_PER_NEURON-1: go to RESP;
    - otherwise k++, clear the timeout counter, go to REQ.
  - RESP: rsp_valid_o = 1; param words and error are held stable. On rsp_ready_i, go to IDLE and clear error.
- Minimum per-word cost: 1 REQ cycle + 1 GAP cycle when ACK is immediate.
- A read command with zero-latency ACKs raises rsp_valid_o 2*WORDS_PER_NEURON + 1 cycles after acceptance.
- Write commands leave the param_word outputs unchanged.
- After a timeout, words not yet fetched keep their previous values.
- cmd_valid_i outside IDLE is ignored; rsp_ready_i outside RESP is ignored.
- wbm_adr_o, wbm_we_o and wbm_sel_o are held stable for the whole REQ phase.

Decomposition:
- Shared package neuron_wb_pkg holds:
  - state encoding (IDLE, REQ, GAP, RESP);
  - PARAM_BASE, NEURON_STRIDE, WORD_OFFSET;
  - SEL_VP = 4'b1000 and the bit-field positions of voltage potential, reset, weights, leak and thresholds, reused by the decode logic.
- One natural sub-module: wb_timeout_counter (enable, clear, expire flag, width from TIMEOUT_CYCLES).

Test Plan:
- Read neuron 0; slave returns 32'h11223344, 32'h55667788, 32'h99AABBCC with 1-cycle ACK.
  - Required: addresses 0x30004010, 0x30004014, 0x30004018; word0..2 match; word3 = 0; rsp_valid_o on cycle 7; error = 0.
- Read neuron 1 with a slave that holds ACK high for 3 cycles after CYC falls.
  - Required: no STB until ACK is low; addresses 0x30004020 onward; exactly 3 transfers.
- Write neuron 5 with vp = 8'hF6.
  - Required: single cycle, adr 0x30004060, WE = 1, SEL = 4'b1000, dat = 32'hF6000000; rsp_valid_o with error 0; param words unchanged.
- Slave never ACKs.
  - Required: STB high exactly 255 cycles, then CYC drops; rsp_valid_o = 1 and rsp_error_o = 1; next command accepted after rsp_ready_i.
- Assert reset during REQ of word 1.
  - Required: CYC/STB low in the same cycle; cmd_ready_o = 1; rsp_valid_o = 0; words = 0.
- Hold rsp_ready_i low for 10 cycles with cmd_valid_i high.
  - Required: responses stable; cmd_ready_o = 0; no bus activity.
